// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcodes,
// the highest legal R-type function code and PC source selects.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b0110;

    localparam logic [3:0] MAX_FUNC = 4'b0011;

    localparam logic [1:0] PCSRC_INC = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    // Anything above jmp is unassigned, as are R-type functions beyond MAX_FUNC.
    function automatic logic is_illegal(input logic [3:0] op, input logic [3:0] fc);
        return (op > OP_JMP) || ((op == OP_RTYPE) && (fc > MAX_FUNC));
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags expiry on the wait cycle that would
// bring the count to TIMEOUT_CYCLES. Used only when MEM_TIMEOUT_EN is defined.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_inc && (r_count == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the 16-bit datapath.
// Define MEM_TIMEOUT_EN to add the memory wait timeout and sticky FAULT state.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic [3:0] function_code,
    input  logic       ctl_reg_write,
    input  logic       ctl_mem_read,
    input  logic       ctl_mem_write,
    input  logic       ctl_branch,
    input  logic       ctl_jump,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_data,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write_en,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       fault,
    output logic [2:0] state
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255) || ((2 ** TMR_W) <= TIMEOUT_CYCLES)) begin : g_bad_params
        $error("multicycle_sequencer: illegal TIMEOUT_CYCLES/TMR_W combination");
    end

    state_t r_state;
    state_t w_state_next;
    state_t w_end_next;
    logic   w_mem_phase;
    logic   w_waiting;
    logic   w_expire;
    logic   w_br_taken;

    assign w_mem_phase = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_waiting   = w_mem_phase && !mem_ready;
    assign w_end_next  = run ? ST_FETCH : ST_IDLE;
    assign w_br_taken  = ctl_branch && (((opcode == OP_BEQ) && alu_zero) ||
                                        ((opcode == OP_BNE) && !alu_zero));

`ifdef MEM_TIMEOUT_EN
    // Held clear outside the memory phases and on each completed handshake,
    // so every FETCH/MEM visit starts counting from zero.
    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_mem_phase || mem_ready),
        .i_inc    (w_waiting),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_is_data   = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PCSRC_INC;
        reg_write_en  = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        fault         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = PCSRC_INC;
                    w_state_next = ST_DECODE;
                end else if (w_expire) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (is_illegal(opcode, function_code)) begin
                    illegal_instr = 1'b1;
                    instr_done    = 1'b1;
                    w_state_next  = w_end_next;
                end else begin
                    w_state_next  = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (ctl_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JMP;
                end else if (w_br_taken) begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_BR;
                end
                if (ctl_mem_read || ctl_mem_write) begin
                    w_state_next = ST_MEM;
                end else if (ctl_reg_write) begin
                    w_state_next = ST_WB;
                end else begin
                    instr_done   = 1'b1;
                    w_state_next = w_end_next;
                end
            end
            ST_MEM: begin
                mem_req     = 1'b1;
                mem_is_data = 1'b1;
                mem_we      = ctl_mem_write;
                if (mem_ready) begin
                    if (ctl_mem_read) begin
                        w_state_next = ST_WB;
                    end else begin
                        instr_done   = 1'b1;
                        w_state_next = w_end_next;
                    end
                end else if (w_expire) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                instr_done   = 1'b1;
                w_state_next = w_end_next;
            end
            ST_FAULT: begin
`ifdef MEM_TIMEOUT_EN
                fault = 1'b1;
`endif
                w_state_next = ST_FAULT;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign state = r_state;

endmodule
